// File: rtl/mem_bus_arbiter.sv
// Byte-wide memory bus arbiter between the core and an external master.
// The external master is granted only at instruction boundaries, and the core is stalled while it owns the bus.
module mem_bus_arbiter #(
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic          cpu_boundary,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  input  logic          ext_rd,
  input  logic          ext_wr,
  output logic          ext_gnt,
  output logic [DW-1:0] ext_rdata,
  output logic          ext_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  localparam logic [1:0] S_CORE = 2'd0;
  localparam logic [1:0] S_EXT  = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_burst_cnt;
  logic          r_cpu_stall;
  logic          r_ext_gnt;
  logic          r_ext_rvalid;
  logic [DW-1:0] r_ext_rdata;

  logic [1:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_stall_nxt;
  logic          w_gnt_nxt;
  logic          w_rvalid_nxt;
  logic [DW-1:0] w_rdata_nxt;

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_CORE;
      r_burst_cnt  <= '0;
      r_cpu_stall  <= 1'b0;
      r_ext_gnt    <= 1'b0;
      r_ext_rvalid <= 1'b0;
      r_ext_rdata  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_burst_cnt  <= w_cnt_nxt;
      r_cpu_stall  <= w_stall_nxt;
      r_ext_gnt    <= w_gnt_nxt;
      r_ext_rvalid <= w_rvalid_nxt;
      r_ext_rdata  <= w_rdata_nxt;
    end
  end

  // Next state, burst counting and bus steering
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_burst_cnt;
    w_rvalid_nxt = 1'b0;
    w_rdata_nxt  = r_ext_rdata;
    mem_addr     = cpu_addr;
    mem_wdata    = cpu_wdata;
    mem_rd       = cpu_rd;
    mem_wr       = cpu_wr;
    case (r_state)
      S_CORE: begin
        if (ext_req && cpu_boundary && !r_cpu_stall) begin
          w_state_nxt = S_EXT;
          w_cnt_nxt   = '0;
        end
      end
      S_EXT: begin
        mem_addr  = ext_addr;
        mem_wdata = ext_wdata;
        mem_rd    = ext_rd && !ext_wr;
        mem_wr    = ext_wr;
        w_cnt_nxt = r_burst_cnt + CW'(1);
        if (ext_rd && !ext_wr) begin
          w_rvalid_nxt = 1'b1;
          w_rdata_nxt  = mem_rdata;
        end
        // The access in the exit cycle still completes
        if (!ext_req || (r_burst_cnt == CNT_LAST)) begin
          w_state_nxt = S_REL;
        end
      end
      S_REL: begin
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        w_state_nxt = S_CORE;
      end
      default: begin
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        w_state_nxt = S_CORE;
      end
    endcase
    w_gnt_nxt   = (w_state_nxt == S_EXT);
    w_stall_nxt = (w_state_nxt != S_CORE);
  end

  assign cpu_rdata  = mem_rdata;
  assign cpu_stall  = r_cpu_stall;
  assign ext_gnt    = r_ext_gnt;
  assign ext_rvalid = r_ext_rvalid;
  assign ext_rdata  = r_ext_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter with MAX_BURST=4.
// Inputs change 1 time unit after each rising clock edge, and outputs are sampled at that same point.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rd;
  logic        cpu_wr;
  logic        cpu_boundary;
  logic [7:0]  cpu_rdata;
  logic        cpu_stall;
  logic        ext_req;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic        ext_rd;
  logic        ext_wr;
  logic        ext_gnt;
  logic [7:0]  ext_rdata;
  logic        ext_rvalid;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_rdata;

  int errors = 0;
  int checks = 0;

  mem_bus_arbiter #(.AW(16), .DW(8), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_boundary(cpu_boundary), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rd(ext_rd), .ext_wr(ext_wr), .ext_gnt(ext_gnt),
    .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_addr = 16'h0200; cpu_wdata = 8'h11; cpu_rd = 1'b0; cpu_wr = 1'b0;
    cpu_boundary = 1'b0; ext_req = 1'b0; ext_addr = 16'h8000; ext_wdata = 8'h22;
    ext_rd = 1'b0; ext_wr = 1'b0; mem_rdata = 8'h00;
  endtask

  // Request at a boundary and enter EXT
  task automatic grant();
    ext_req = 1'b1; cpu_boundary = 1'b1;
    tick();
    cpu_boundary = 1'b0;
  endtask

  // Drop the request: one exit EXT cycle, then RELEASE, then CORE
  task automatic release_bus();
    ext_req = 1'b0; ext_rd = 1'b0; ext_wr = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    checks++; if (ext_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0", ext_gnt); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
    checks++; if ({ext_rvalid, ext_rdata} !== 9'h000) begin errors++; $display("FAIL reset_rdata: got %b/%h want 0/00", ext_rvalid, ext_rdata); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_core_passthrough();
    cpu_addr = 16'h0345; cpu_wdata = 8'h77; cpu_wr = 1'b1;
    ext_rd = 1'b1; ext_wr = 1'b1; mem_rdata = 8'h9E;
    #1;
    checks++; if ({mem_addr, mem_wdata, mem_rd, mem_wr} !== {16'h0345, 8'h77, 1'b0, 1'b1})
      begin errors++; $display("FAIL core_wr: got %h %h %b%b want 0345 77 01", mem_addr, mem_wdata, mem_rd, mem_wr); end
    checks++; if (cpu_rdata !== 8'h9E) begin errors++; $display("FAIL cpu_rdata: got %h want 9e", cpu_rdata); end
    cpu_wr = 1'b0;
    #1;
    checks++; if ({mem_rd, mem_wr} !== 2'b00) begin errors++; $display("FAIL ext_strobe_outside: got %b%b want 00", mem_rd, mem_wr); end
    idle_inputs();
    tick();
  endtask

  task automatic test_boundary_grant();
    // Phase 1 completes, then the request rises during phase 2
    cpu_addr = 16'h0100; cpu_rd = 1'b1;
    tick();
    ext_req = 1'b1; cpu_addr = 16'h0101;
    tick();
    checks++; if (ext_gnt !== 1'b0) begin errors++; $display("FAIL no_grant_midop: got %b want 0", ext_gnt); end
    cpu_boundary = 1'b1; cpu_addr = 16'h0102;
    #1;
    checks++; if ({mem_addr, mem_rd} !== {16'h0102, 1'b1}) begin errors++; $display("FAIL boundary_access: got %h %b want 0102 1", mem_addr, mem_rd); end
    tick();
    cpu_boundary = 1'b0;
    checks++; if ({ext_gnt, cpu_stall} !== 2'b11) begin errors++; $display("FAIL grant_after_boundary: got %b%b want 11", ext_gnt, cpu_stall); end
    checks++; if ({mem_addr, mem_rd, mem_wr} !== {16'h8000, 1'b0, 1'b0}) begin errors++; $display("FAIL ext_ignores_cpu: got %h %b%b want 8000 00", mem_addr, mem_rd, mem_wr); end
    ext_req = 1'b0;
    tick();
    checks++; if ({ext_gnt, cpu_stall, mem_rd, mem_wr} !== 4'b0100) begin errors++; $display("FAIL release_cycle: got %b%b%b%b want 0100", ext_gnt, cpu_stall, mem_rd, mem_wr); end
    tick();
    checks++; if ({ext_gnt, cpu_stall} !== 2'b00) begin errors++; $display("FAIL back_to_core: got %b%b want 00", ext_gnt, cpu_stall); end
    idle_inputs();
  endtask

  task automatic test_ext_read();
    grant();
    ext_addr = 16'h1234; ext_rd = 1'b1; mem_rdata = 8'hA5;
    #1;
    checks++; if ({mem_addr, mem_rd, mem_wr} !== {16'h1234, 1'b1, 1'b0}) begin errors++; $display("FAIL ext_read_bus: got %h %b%b want 1234 10", mem_addr, mem_rd, mem_wr); end
    tick();
    ext_rd = 1'b0; mem_rdata = 8'h00;
    checks++; if ({ext_rvalid, ext_rdata} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL ext_read_data: got %b/%h want 1/a5", ext_rvalid, ext_rdata); end
    tick();
    checks++; if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_pulse: got %b want 0", ext_rvalid); end
    release_bus();
    idle_inputs();
  endtask

  task automatic test_max_burst();
    int n;
    n = 0;
    grant();
    for (int i = 0; i < 10; i++) begin
      if (ext_gnt !== 1'b1) break;
      n++;
      tick();
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL burst_len: got %0d want 4", n); end
    checks++; if ({ext_gnt, cpu_stall} !== 2'b01) begin errors++; $display("FAIL burst_release: got %b%b want 01", ext_gnt, cpu_stall); end
    tick();
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL burst_core: got %b want 0", cpu_stall); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ext_gnt !== 1'b0) begin errors++; $display("FAIL no_regrant_%0d: got %b want 0", i, ext_gnt); end
    end
    cpu_boundary = 1'b1;
    tick();
    cpu_boundary = 1'b0;
    checks++; if (ext_gnt !== 1'b1) begin errors++; $display("FAIL regrant: got %b want 1", ext_gnt); end
    release_bus();
    idle_inputs();
  endtask

  task automatic test_early_drop();
    int n;
    n = 0;
    grant();
    tick();
    // Second EXT cycle is the exit cycle and carries a read
    ext_req = 1'b0; ext_rd = 1'b1; ext_addr = 16'h0042; mem_rdata = 8'h5A;
    tick();
    ext_rd = 1'b0; mem_rdata = 8'h00;
    checks++; if ({ext_gnt, cpu_stall} !== 2'b01) begin errors++; $display("FAIL drop_release: got %b%b want 01", ext_gnt, cpu_stall); end
    checks++; if ({ext_rvalid, ext_rdata} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL release_rvalid: got %b/%h want 1/5a", ext_rvalid, ext_rdata); end
    tick();
    checks++; if ({ext_gnt, cpu_stall} !== 2'b00) begin errors++; $display("FAIL drop_core: got %b%b want 00", ext_gnt, cpu_stall); end
    grant();
    for (int i = 0; i < 10; i++) begin
      if (ext_gnt !== 1'b1) break;
      n++;
      tick();
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL burst_restart: got %0d want 4", n); end
    tick();
    idle_inputs();
  endtask

  task automatic test_rd_wr_both();
    grant();
    ext_rd = 1'b1; ext_wr = 1'b1; ext_addr = 16'h0010; ext_wdata = 8'h3C;
    #1;
    checks++; if ({mem_addr, mem_wdata, mem_rd, mem_wr} !== {16'h0010, 8'h3C, 1'b0, 1'b1})
      begin errors++; $display("FAIL rdwr_bus: got %h %h %b%b want 0010 3c 01", mem_addr, mem_wdata, mem_rd, mem_wr); end
    tick();
    checks++; if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL rdwr_rvalid: got %b want 0", ext_rvalid); end
    release_bus();
    idle_inputs();
  endtask

  task automatic test_reset_mid_ext();
    grant();
    ext_wr = 1'b1; cpu_addr = 16'h0ABC; cpu_wr = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({ext_gnt, cpu_stall} !== 2'b00) begin errors++; $display("FAIL reset_mid_ext: got %b%b want 00", ext_gnt, cpu_stall); end
    checks++; if ({mem_addr, mem_wr} !== {16'h0ABC, 1'b0}) begin errors++; $display("FAIL reset_mid_ext_bus: got %h %b want 0abc 0", mem_addr, mem_wr); end
    tick();
    reset = 1'b0;
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_core_passthrough();
    test_boundary_grant();
    test_ext_read();
    test_max_burst();
    test_early_drop();
    test_rd_wr_both();
    test_reset_mid_ext();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
